// File: rtl/seg7_pkg.sv
// Shared types, segment patterns and helper functions for the seg7_scan_bcd display driver.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Largest value representable on n decimal digits
    function automatic logic [31:0] pow10_max(input int unsigned n);
        logic [31:0] p;
        p = 32'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p - 32'd1;
    endfunction

endpackage

// File: rtl/seg7_dd_core.sv
// Serial double-dabble datapath: shift/add-3 register, bit counter and done pulse.
module seg7_dd_core
    import seg7_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                shift_en,
    input  logic [DATA_W-1:0]   bin_in,
    output logic [4*DIGITS-1:0] bcd,
    output logic                done
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] shift_r;
    logic [BCD_W-1:0]  bcd_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [BCD_W-1:0]  adj_s;

    // Add-3 correction on every nibble that would exceed 9 after the shift
    always_comb begin
        adj_s = bcd_r;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_r[4*k +: 4] >= 4'd5) begin
                adj_s[4*k +: 4] = bcd_r[4*k +: 4] + 4'd3;
            end else begin
                adj_s[4*k +: 4] = bcd_r[4*k +: 4];
            end
        end
    end

    // Capture, shift and bit-count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= '0;
            bcd_r   <= '0;
            cnt_r   <= '0;
        end else if (start) begin
            shift_r <= bin_in;
            bcd_r   <= '0;
            cnt_r   <= '0;
        end else if (shift_en) begin
            bcd_r   <= {adj_s[BCD_W-2:0], shift_r[DATA_W-1]};
            shift_r <= shift_r << 1;
            cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            shift_r <= shift_r;
            bcd_r   <= bcd_r;
            cnt_r   <= cnt_r;
        end
    end

    assign bcd  = bcd_r;
    assign done = shift_en && (cnt_r == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/seg7_scan_bcd.sv
// Binary-to-BCD multiplexed seven-segment driver; define SEG7_BLANK_EN for leading-zero blanking.
module seg7_scan_bcd
    import seg7_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              ovf,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int          BCD_W     = 4 * DIGITS;
    localparam int          REF_W     = $clog2(REFRESH_DIV);
    localparam int          IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [31:0] OVF_LIMIT = pow10_max(DIGITS);

    state_t             state_r, next_s;
    logic               capture_s, shift_en_s, commit_s, done_s;
    logic [BCD_W-1:0]   scratch_s;
    logic [BCD_W-1:0]   disp_r;
    logic               ovf_cap_r, ovf_r, busy_r;
    logic [REF_W-1:0]   ref_cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic [3:0]         nib_a [DIGITS];
    logic [DIGITS-1:0]  blank_s;
    logic [6:0]         seg_s, seg_r;
    logic [DIGITS-1:0]  an_s, an_r;

    seg7_dd_core #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_core (
        .clk      (clk),
        .rst_n    (rst),
        .start    (capture_s),
        .shift_en (shift_en_s),
        .bin_in   (data_in),
        .bcd      (scratch_s),
        .done     (done_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE:    if (load) next_s = CONVERT; else next_s = IDLE;
            CONVERT: if (done_s) next_s = COMMIT; else next_s = CONVERT;
            COMMIT:  next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // FSM control strobes
    always_comb begin
        capture_s  = 1'b0;
        shift_en_s = 1'b0;
        commit_s   = 1'b0;
        case (state_r)
            IDLE:    capture_s  = load;
            CONVERT: shift_en_s = 1'b1;
            COMMIT:  commit_s   = 1'b1;
            default: capture_s  = 1'b0;
        endcase
    end

    // Handshake, overflow and display registers; overflow is judged on the raw captured value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r    <= 1'b0;
            ovf_cap_r <= 1'b0;
            ovf_r     <= 1'b0;
            disp_r    <= '0;
        end else begin
            busy_r <= (next_s != IDLE);
            if (capture_s) begin
                ovf_cap_r <= ({{(32-DATA_W){1'b0}}, data_in} > OVF_LIMIT);
            end else begin
                ovf_cap_r <= ovf_cap_r;
            end
            if (commit_s) begin
                disp_r <= scratch_s;
                ovf_r  <= ovf_cap_r;
            end else begin
                disp_r <= disp_r;
                ovf_r  <= ovf_r;
            end
        end
    end

    // Refresh divider and digit index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_cnt_r <= '0;
            idx_r     <= '0;
        end else if (ref_cnt_r == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt_r <= '0;
            if (idx_r == IDX_W'(DIGITS - 1)) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ref_cnt_r <= ref_cnt_r + {{(REF_W-1){1'b0}}, 1'b1};
            idx_r     <= idx_r;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_nib
        assign nib_a[k] = disp_r[4*k +: 4];
    end

    // Leading-zero mask: digit k>0 blanks when it and every higher digit are zero
    always_comb begin
        blank_s = '0;
`ifdef SEG7_BLANK_EN
        begin
            logic zero_above;
            zero_above = 1'b1;
            for (int k = DIGITS - 1; k > 0; k--) begin
                zero_above = zero_above && (nib_a[k] == 4'd0);
                blank_s[k] = zero_above;
            end
        end
`endif
    end

    // Digit mux and decode
    always_comb begin
        an_s = ~(DIGITS'(1) << idx_r);
        if (ovf_r) begin
            seg_s = SEG_DASH;
        end else if (blank_s[idx_r]) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = seg_decode(nib_a[idx_r]);
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_r <= SEG_BLANK;
            an_r  <= '1;
        end else begin
            seg_r <= seg_s;
            an_r  <= an_s;
        end
    end

    assign busy = busy_r;
    assign ovf  = ovf_r;
    assign seg  = seg_r;
    assign an   = an_r;

endmodule
